shift_issue_stage: RTL and testbench

//   Registered valid/ready issue stage wrapped around the barrel shifter datapath.

---
 rtl/shift_issue_stage.sv | 137 +++++++++++++
 tb/tb_shift_issue_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: registered valid/ready issue stage around a barrel shifter.
// The stage holds up to two requests. The result register R holds one shifted result.
// The skid register S holds one raw request. in_ready comes from a flop, so it has
// no combinational path from out_ready.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     request handshake (in_ready registered)
//   in_alufn              00 SHL, 01 SHR, 11 SRA, 10 illegal
//   in_a, in_b            operand and unsigned shift amount
//   out_valid/out_ready   result handshake
//   out_result            shifted value (0 for illegal alufn)
//   out_illegal           result came from alufn=10
//   op_count              accepted-request counter, wraps mod 2^16
module shift_issue_stage #(
  parameter  int unsigned BITS = 32,
  localparam int unsigned SHW  = $clog2(BITS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_alufn,
  input  logic [BITS-1:0] in_a,
  input  logic [SHW-1:0]  in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_result,
  output logic            out_illegal,
  output logic [15:0]     op_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          state;

  logic [1:0]      skid_alufn;
  logic [BITS-1:0] skid_a;
  logic [SHW-1:0]  skid_b;

  logic            in_xfer;
  logic            out_xfer;
  logic [1:0]      sel_alufn;
  logic [BITS-1:0] sel_a;
  logic [SHW-1:0]  sel_b;
  logic [BITS-1:0] sh_result;
  logic            sh_illegal;

  // Handshakes and shifter operand select. In FULL, R is only reloaded from the skid.
  always_comb begin
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_valid & out_ready;
    sel_alufn = in_alufn;
    sel_a     = in_a;
    sel_b     = in_b;
    if (state == ST_FULL) begin
      sel_alufn = skid_alufn;
      sel_a     = skid_a;
      sel_b     = skid_b;
    end
  end

  // Single shared shifter evaluated on the selected operands.
  always_comb begin
    sh_result  = '0;
    sh_illegal = 1'b0;
    unique case (sel_alufn)
      2'b00:   sh_result = sel_a << sel_b;
      2'b01:   sh_result = sel_a >> sel_b;
      2'b11:   sh_result = BITS'($signed(sel_a) >>> sel_b);
      default: sh_illegal = 1'b1;
    endcase
  end

  // State register, result and skid registers, registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
      in_ready    <= 1'b1;
      op_count    <= 16'd0;
      skid_alufn  <= 2'b00;
      skid_a      <= '0;
      skid_b      <= '0;
    end else begin
      if (in_xfer) begin
        op_count <= op_count + 16'd1;
      end
      unique case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_result  <= sh_result;
            out_illegal <= sh_illegal;
            out_valid   <= 1'b1;
            state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            out_result  <= sh_result;
            out_illegal <= sh_illegal;
          end else if (in_xfer) begin
            // Consumer stalled: park the raw request and stop accepting.
            skid_alufn <= in_alufn;
            skid_a     <= in_a;
            skid_b     <= in_b;
            in_ready   <= 1'b0;
            state      <= ST_FULL;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            out_result  <= sh_result;
            out_illegal <= sh_illegal;
            in_ready    <= 1'b1;
            state       <= ST_BUSY;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Testbench for shift_issue_stage. The reference model treats the stage as a
// two-entry FIFO of expected results. The shifts are computed with integer arithmetic.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_alufn;
  logic [31:0] in_a;
  logic [4:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;
  logic [15:0] op_count;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] exp_res[$];
  logic        exp_ill[$];
  logic [15:0] exp_cnt;

  shift_issue_stage #(.BITS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alufn   (in_alufn),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_illegal(out_illegal),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shift reference computed by multiplication, division and floor division.
  task automatic ref_shift(input logic [1:0] fn, input logic [31:0] a, input logic [4:0] b,
                           output logic [31:0] res, output logic ill);
    longint unsigned p2;
    longint unsigned prod;
    longint          sa;
    longint          q;
    p2  = 64'd1 << b;
    ill = 1'b0;
    res = 32'd0;
    case (fn)
      2'b00: begin
        prod = longint'(a) * p2;
        res  = prod[31:0];
      end
      2'b01: res = 32'(longint'(a) / p2);
      2'b11: begin
        sa = a[31] ? (longint'(a) - 64'sh1_0000_0000) : longint'(a);
        q  = sa / longint'(p2);
        if (sa < 0 && (sa % longint'(p2)) != 0) q = q - 1;
        res = q[31:0];
      end
      default: ill = 1'b1;
    endcase
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(exp_res.size() > 0));
    check("in_ready", 32'(in_ready), 32'(exp_res.size() < 2));
    check("op_count", 32'(op_count), 32'(exp_cnt));
    if (exp_res.size() > 0) begin
      check("out_result", out_result, exp_res[0]);
      check("out_illegal", 32'(out_illegal), 32'(exp_ill[0]));
    end
  endtask

  // Drive one cycle of inputs (at negedge), advance the model, then check after the edge.
  task automatic step(input logic iv, input logic [1:0] fn, input logic [31:0] a,
                      input logic [4:0] b, input logic ordy);
    logic        ix;
    logic        ox;
    logic [31:0] r;
    logic        il;
    in_valid  = iv;
    in_alufn  = fn;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    ix = iv && (exp_res.size() < 2);
    ox = ordy && (exp_res.size() > 0);
    if (ox) begin
      void'(exp_res.pop_front());
      void'(exp_ill.pop_front());
    end
    if (ix) begin
      ref_shift(fn, a, b, r, il);
      exp_res.push_back(r);
      exp_ill.push_back(il);
      exp_cnt = exp_cnt + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    in_valid  = 1'($urandom);
    out_ready = 1'($urandom);
    in_alufn  = 2'($urandom);
    in_a      = $urandom;
    in_b      = 5'($urandom);
    repeat (n) @(posedge clk);
    @(negedge clk);
    exp_res.delete();
    exp_ill.delete();
    exp_cnt = 16'd0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_alufn  = 2'b00;
    in_a      = 32'd0;
    in_b      = 5'd0;
    exp_cnt   = 16'd0;

    // Reset for two cycles.
    do_reset(2);
    step(1'b0, 2'b00, 32'd0, 5'd0, 1'b1);

    // Directed shifts with known constant results.
    step(1'b1, 2'b00, 32'h0000_0001, 5'd31, 1'b1);
    check("shl_31", out_result, 32'h8000_0000);
    check("shl_31_ill", 32'(out_illegal), 32'd0);
    step(1'b1, 2'b11, 32'h8000_0000, 5'd4, 1'b1);
    check("sra_4", out_result, 32'hF800_0000);
    step(1'b1, 2'b01, 32'h8000_0000, 5'd4, 1'b1);
    check("shr_4", out_result, 32'h0800_0000);
    step(1'b1, 2'b11, 32'h1234_5678, 5'd0, 1'b1);
    check("b0_pass", out_result, 32'h1234_5678);
    step(1'b0, 2'b00, 32'd0, 5'd0, 1'b1);

    // Stall: the first request goes to R, the second to S, the third waits upstream.
    step(1'b1, 2'b00, 32'h0000_0003, 5'd1, 1'b0);
    step(1'b1, 2'b01, 32'h0000_0100, 5'd4, 1'b0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 2'b11, 32'hF000_0000, 5'd8, 1'b0);
    check("stall_head", out_result, 32'h0000_0006);
    step(1'b1, 2'b11, 32'hF000_0000, 5'd8, 1'b1);
    check("drain_2nd", out_result, 32'h0000_0010);
    step(1'b1, 2'b11, 32'hF000_0000, 5'd8, 1'b1);
    check("drain_3rd", out_result, 32'hFFF0_0000);
    step(1'b0, 2'b00, 32'd0, 5'd0, 1'b1);
    check("drained", 32'(out_valid), 32'd0);

    // Illegal alufn.
    step(1'b1, 2'b10, 32'hFFFF_FFFF, 5'd3, 1'b1);
    check("illegal_res", out_result, 32'd0);
    check("illegal_flag", 32'(out_illegal), 32'd1);
    check("illegal_cnt", 32'(op_count), 32'd8);
    step(1'b0, 2'b00, 32'd0, 5'd0, 1'b1);

    // Fill to FULL, then reset mid-flight.
    step(1'b1, 2'b00, 32'h0000_00AA, 5'd2, 1'b0);
    step(1'b1, 2'b00, 32'h0000_00BB, 5'd2, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    do_reset(1);
    step(1'b0, 2'b00, 32'd0, 5'd0, 1'b1);
    check("no_stale", 32'(out_valid), 32'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399, 0) == 0) begin
        do_reset(1);
      end else begin
        step(1'($urandom_range(9, 0) < 7), 2'($urandom), $urandom, 5'($urandom),
             1'($urandom_range(9, 0) < 6));
      end
    end

    // Counter wrap: 65536 accepts from reset.
    do_reset(1);
    for (int i = 0; i < 65536; i++) begin
      step(1'b1, 2'($urandom), $urandom, 5'($urandom), 1'b1);
      if (i == 65534) check("cnt_ffff", 32'(op_count), 32'h0000_FFFF);
    end
    check("cnt_wrap", 32'(op_count), 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
